program_loader: RTL and testbench

- Boot/run controller placed between a host or bench stream and the computer's program and data memories.
- While holding the core in reset it:
  - optionally clears both memories (program memory to HALT_WORD, data memory to zero),
  - streams tagged words into either memory over a valid/ready handshake,
  - releases the core and supervises execution until the core reports halt or a cycle budget expires.
- Replaces hierarchical memory preloading with a synthesizable, parametrised load/run path.

---
 rtl/program_loader.sv | 201 ++++++++++++++++++++
 tb/tb_program_loader.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
`default_nettype none

`ifndef HALT_INST
`define HALT_INST 16'hF000
`endif

// ============================================================================
// Module      : program_loader
// Description : Boot/run controller that sits between a host word stream and
//               the program/data memories of a small computer core. While the
//               core is held in reset it optionally clears both memories,
//               then accepts tagged words over a valid/ready handshake and
//               writes them into the selected memory. It then releases the
//               core and supervises it until halt or a cycle budget expires.
//
// Ports       : clock, reset          - rising-edge clock, async active-high
//               start                 - begin a sequence (IDLE/DONE only)
//               load_valid/ready      - stream handshake
//               load_target           - 0 = program memory, 1 = data memory
//               load_address/data     - beat address and word
//               load_last             - final beat of the stream
//               core_halted           - core has executed HALT
//               prog_write_*          - program memory write port
//               data_write_*          - data memory write port
//               core_reset            - active-high reset to the core
//               busy/done/timeout     - sequence status
//               cycle_count           - RUN cycles with the core released
//
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int                    INST_WIDTH      = 16,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    PROG_ADDR_WIDTH = 6,
    parameter int                    DATA_ADDR_WIDTH = 6,
    parameter logic [INST_WIDTH-1:0] HALT_WORD       = `HALT_INST,
    parameter int                    CLEAR_ENABLE    = 1,
    parameter int                    MAX_RUN_CYCLES  = 50,
    parameter int                    COUNT_WIDTH     = 16,
    localparam int                   LOAD_ADDR_WIDTH =
        (PROG_ADDR_WIDTH > DATA_ADDR_WIDTH) ? PROG_ADDR_WIDTH : DATA_ADDR_WIDTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic                       load_target,
    input  logic [LOAD_ADDR_WIDTH-1:0] load_address,
    input  logic [DATA_WIDTH-1:0]      load_data,
    input  logic                       load_last,
    input  logic                       core_halted,
    output logic                       prog_write_enable,
    output logic [PROG_ADDR_WIDTH-1:0] prog_write_address,
    output logic [INST_WIDTH-1:0]      prog_write_data,
    output logic                       data_write_enable,
    output logic [DATA_ADDR_WIDTH-1:0] data_write_address,
    output logic [DATA_WIDTH-1:0]      data_write_data,
    output logic                       core_reset,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout,
    output logic [COUNT_WIDTH-1:0]     cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] c_run_limit = COUNT_WIDTH'(MAX_RUN_CYCLES);

    state_t                      r_state;
    state_t                      w_next;
    logic [LOAD_ADDR_WIDTH-1:0]  r_clear_idx;
    logic                        r_run_active;
    logic [COUNT_WIDTH-1:0]      r_cycle_count;
    logic                        r_timeout;

    logic                        r_prog_we;
    logic [PROG_ADDR_WIDTH-1:0]  r_prog_addr;
    logic [INST_WIDTH-1:0]       r_prog_data;
    logic                        r_data_we;
    logic [DATA_ADDR_WIDTH-1:0]  r_data_addr;
    logic [DATA_WIDTH-1:0]       r_data_data;

    logic w_accept;
    logic w_start_seq;
    logic w_clear_last;
    logic w_in_clear;
    logic w_clear_prog;
    logic w_clear_data;
    logic w_limit_hit;

    assign load_ready   = (r_state == S_LOAD);
    assign w_accept     = load_valid && load_ready;
    assign w_start_seq  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_clear_last = (r_clear_idx == '1);
    assign w_in_clear   = (r_state == S_CLEAR);
    // The clear index sweeps the larger memory; the smaller one is only
    // written while the index still fits inside its address range.
    assign w_clear_prog = ((r_clear_idx >> PROG_ADDR_WIDTH) == '0);
    assign w_clear_data = ((r_clear_idx >> DATA_ADDR_WIDTH) == '0);
    assign w_limit_hit  = (r_cycle_count == c_run_limit);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_next = (CLEAR_ENABLE != 0) ? S_CLEAR : S_LOAD;
                end
            end
            S_CLEAR: begin
                if (w_clear_last) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_accept && load_last) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (core_halted || w_limit_hit) begin
                    w_next = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_clear_idx   <= '0;
            r_run_active  <= 1'b0;
            r_cycle_count <= '0;
            r_timeout     <= 1'b0;
            r_prog_we     <= 1'b0;
            r_prog_addr   <= '0;
            r_prog_data   <= '0;
            r_data_we     <= 1'b0;
            r_data_addr   <= '0;
            r_data_data   <= '0;
        end else begin
            r_state     <= w_next;
            r_clear_idx <= w_in_clear ? (r_clear_idx + LOAD_ADDR_WIDTH'(1)) : '0;

            // The first RUN cycle keeps the core in reset so the write of the
            // last beat lands before the core starts fetching.
            r_run_active <= (r_state == S_RUN) && (w_next == S_RUN);

            if (w_start_seq) begin
                r_cycle_count <= '0;
            end else if ((r_state == S_LOAD) && (w_next == S_RUN)) begin
                r_cycle_count <= '0;
            end else if ((r_state == S_RUN) && r_run_active && (w_next == S_RUN)
                         && (r_cycle_count != '1)) begin
                r_cycle_count <= r_cycle_count + COUNT_WIDTH'(1);
            end

            // Halt takes priority over an expiring budget in the same cycle.
            if (w_start_seq) begin
                r_timeout <= 1'b0;
            end else if ((r_state == S_RUN) && (w_next == S_DONE)) begin
                r_timeout <= !core_halted;
            end

            r_prog_we <= w_accept && !load_target;
            r_data_we <= w_accept && load_target;
            if (w_accept && !load_target) begin
                r_prog_addr <= load_address[PROG_ADDR_WIDTH-1:0];
                r_prog_data <= load_data[INST_WIDTH-1:0];
            end
            if (w_accept && load_target) begin
                r_data_addr <= load_address[DATA_ADDR_WIDTH-1:0];
                r_data_data <= load_data;
            end
        end
    end

    assign prog_write_enable  = (w_in_clear && w_clear_prog) || r_prog_we;
    assign prog_write_address = w_in_clear ? r_clear_idx[PROG_ADDR_WIDTH-1:0] : r_prog_addr;
    assign prog_write_data    = w_in_clear ? HALT_WORD : r_prog_data;
    assign data_write_enable  = (w_in_clear && w_clear_data) || r_data_we;
    assign data_write_address = w_in_clear ? r_clear_idx[DATA_ADDR_WIDTH-1:0] : r_data_addr;
    assign data_write_data    = w_in_clear ? '0 : r_data_data;

    assign core_reset  = !(((r_state == S_RUN) && r_run_active) || (r_state == S_DONE));
    assign busy        = (r_state == S_CLEAR) || (r_state == S_LOAD) || (r_state == S_RUN);
    assign done        = (r_state == S_DONE);
    assign timeout     = r_timeout;
    assign cycle_count = r_cycle_count;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none

// ============================================================================
// Module      : tb_program_loader
// Description : Self-checking bench for program_loader. Instance A uses the
//               default geometry with clearing; instance B has no clear phase
//               and a 16-word data memory. Memory contents and write strobes
//               are checked against a reference model of the load/run rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    localparam logic [15:0] HALT   = 16'hF000;
    localparam int          MAXRUN = 50;

    typedef struct packed {
        logic        tgt;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [31:0] cyc;
    } wr_t;

    typedef struct {
        logic        tgt;
        logic [5:0]  addr;
        logic [31:0] data;
    } beat_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic        reset;
    logic        start, load_valid, load_ready, load_target, load_last, core_halted;
    logic [5:0]  load_address;
    logic [31:0] load_data;
    logic        prog_write_enable, data_write_enable;
    logic [5:0]  prog_write_address, data_write_address;
    logic [15:0] prog_write_data;
    logic [31:0] data_write_data;
    logic        core_reset, busy, done, timeout;
    logic [15:0] cycle_count;

    logic        b_start, b_load_valid, b_load_ready, b_load_target, b_load_last, b_core_halted;
    logic [5:0]  b_load_address;
    logic [31:0] b_load_data;
    logic        b_prog_write_enable, b_data_write_enable;
    logic [5:0]  b_prog_write_address;
    logic [3:0]  b_data_write_address;
    logic [15:0] b_prog_write_data;
    logic [31:0] b_data_write_data;
    logic        b_core_reset, b_busy, b_done, b_timeout;
    logic [15:0] b_cycle_count;

    program_loader #(
        .HALT_WORD      (HALT),
        .MAX_RUN_CYCLES (MAXRUN)
    ) dut_a (
        .clock              (clock),
        .reset              (reset),
        .start              (start),
        .load_valid         (load_valid),
        .load_ready         (load_ready),
        .load_target        (load_target),
        .load_address       (load_address),
        .load_data          (load_data),
        .load_last          (load_last),
        .core_halted        (core_halted),
        .prog_write_enable  (prog_write_enable),
        .prog_write_address (prog_write_address),
        .prog_write_data    (prog_write_data),
        .data_write_enable  (data_write_enable),
        .data_write_address (data_write_address),
        .data_write_data    (data_write_data),
        .core_reset         (core_reset),
        .busy               (busy),
        .done               (done),
        .timeout            (timeout),
        .cycle_count        (cycle_count)
    );

    program_loader #(
        .HALT_WORD       (HALT),
        .CLEAR_ENABLE    (0),
        .DATA_ADDR_WIDTH (4),
        .MAX_RUN_CYCLES  (MAXRUN)
    ) dut_b (
        .clock              (clock),
        .reset              (reset),
        .start              (b_start),
        .load_valid         (b_load_valid),
        .load_ready         (b_load_ready),
        .load_target        (b_load_target),
        .load_address       (b_load_address),
        .load_data          (b_load_data),
        .load_last          (b_load_last),
        .core_halted        (b_core_halted),
        .prog_write_enable  (b_prog_write_enable),
        .prog_write_address (b_prog_write_address),
        .prog_write_data    (b_prog_write_data),
        .data_write_enable  (b_data_write_enable),
        .data_write_address (b_data_write_address),
        .data_write_data    (b_data_write_data),
        .core_reset         (b_core_reset),
        .busy               (b_busy),
        .done               (b_done),
        .timeout            (b_timeout),
        .cycle_count        (b_cycle_count)
    );

    int vectors    = 0;
    int miscompares = 0;

    wr_t   log_q[$];
    wr_t   exp_q[$];
    wr_t   b_log_q[$];
    beat_t beats[$];

    logic [15:0] shadow_prog[64];
    logic [31:0] shadow_data[64];
    logic [15:0] model_prog[64];
    logic [31:0] model_data[64];

    function automatic wr_t mk(input logic t, input logic [5:0] a, input logic [31:0] d, input int c);
        wr_t w;
        w.tgt  = t;
        w.addr = a;
        w.data = d;
        w.cyc  = 32'(c);
        return w;
    endfunction

    function automatic beat_t mkbeat(input logic t, input logic [5:0] a, input logic [31:0] d);
        beat_t b;
        b.tgt  = t;
        b.addr = a;
        b.data = d;
        return b;
    endfunction

    // Observed write strobes, sampled mid-cycle.
    always @(negedge clock) begin
        if (prog_write_enable) begin
            log_q.push_back(mk(1'b0, prog_write_address, {16'h0, prog_write_data}, cyc));
            shadow_prog[prog_write_address] = prog_write_data;
        end
        if (data_write_enable) begin
            log_q.push_back(mk(1'b1, data_write_address, data_write_data, cyc));
            shadow_data[data_write_address] = data_write_data;
        end
        if (b_prog_write_enable)
            b_log_q.push_back(mk(1'b0, b_prog_write_address, {16'h0, b_prog_write_data}, cyc));
        if (b_data_write_enable)
            b_log_q.push_back(mk(1'b1, {2'b00, b_data_write_address}, b_data_write_data, cyc));
    end

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic compare_logs(input string tag);
        int n;
        check($sformatf("%s_count", tag), 96'(log_q.size()), 96'(exp_q.size()));
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_entry%0d", tag, i), log_q[i], exp_q[i]);
            if (log_q[i] !== exp_q[i]) break;
        end
        log_q.delete();
        exp_q.delete();
    endtask

    // Start a sequence and expect a full 64-address clear of both memories.
    task automatic clear_and_check();
        int s;
        int n;
        log_q.delete();
        exp_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        s = cyc;
        check("start_busy", busy, 1);
        check("start_done_cleared", done, 0);
        check("start_timeout_cleared", timeout, 0);
        check("start_count_cleared", cycle_count, 0);
        check("start_core_reset", core_reset, 1);
        n = 0;
        while (!load_ready && n < 200) begin
            tick();
            n++;
        end
        check("clear_cycles", 96'(n), 96'(64));
        for (int k = 0; k < 64; k++) begin
            exp_q.push_back(mk(1'b0, 6'(k), {16'h0, HALT}, s + k));
            exp_q.push_back(mk(1'b1, 6'(k), 32'h0, s + k));
            model_prog[k] = HALT;
            model_data[k] = 32'h0;
        end
        compare_logs("clear_log");
    endtask

    task automatic send_beats(input bit toggle, output int acc);
        int n_b;
        int gap;
        n_b = beats.size();
        acc = cyc;
        for (int i = 0; i < n_b; i++) begin
            gap = toggle ? ((i == 0) ? 0 : 1) : int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                // Idle cycle with junk fields plus ignored start/halt pulses.
                load_valid   = 1'b0;
                load_target  = 1'($urandom_range(0, 1));
                load_address = 6'($urandom);
                load_data    = $urandom;
                load_last    = 1'($urandom_range(0, 1));
                start        = 1'($urandom_range(0, 1));
                core_halted  = 1'($urandom_range(0, 1));
                tick();
            end
            start        = 1'b0;
            core_halted  = 1'b0;
            load_valid   = 1'b1;
            load_target  = beats[i].tgt;
            load_address = beats[i].addr;
            load_data    = beats[i].data;
            load_last    = (i == n_b - 1);
            check("ready_before_beat", load_ready, 1);
            tick();
            acc = cyc;
            if (beats[i].tgt) begin
                exp_q.push_back(mk(1'b1, beats[i].addr, beats[i].data, acc));
                model_data[beats[i].addr] = beats[i].data;
            end else begin
                exp_q.push_back(mk(1'b0, beats[i].addr, {16'h0, beats[i].data[15:0]}, acc));
                model_prog[beats[i].addr] = beats[i].data[15:0];
            end
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    // h >= 0: halt raised when exactly h released cycles have elapsed.
    // h <  0: core never halts, budget must expire.
    task automatic run_phase(input int h, input int acc);
        int n;
        int exp_done;
        int bad;
        logic [15:0] held;
        check("first_run_core_reset", core_reset, 1);
        check("first_run_ready", load_ready, 0);
        check("first_run_busy", busy, 1);
        tick();
        check("core_reset_released", core_reset, 0);
        exp_done = (h >= 0) ? acc + h + 2 : acc + MAXRUN + 2;
        n = 0;
        while (!done && n < 400) begin
            core_halted = (h >= 0) && (cyc == acc + h + 1);
            tick();
            n++;
        end
        core_halted = 1'b0;
        check("done_seen", done, 1);
        check("done_cycle", 96'(cyc), 96'(exp_done));
        check("timeout", timeout, (h < 0));
        check("cycle_count", cycle_count, (h >= 0) ? 96'(h) : 96'(MAXRUN));
        check("done_busy", busy, 0);
        check("done_core_reset", core_reset, 0);
        compare_logs("load_writes");
        bad = 0;
        for (int k = 0; k < 64; k++) if (shadow_prog[k] !== model_prog[k]) bad++;
        check("prog_mem_mismatches", 96'(bad), 96'(0));
        bad = 0;
        for (int k = 0; k < 64; k++) if (shadow_data[k] !== model_data[k]) bad++;
        check("data_mem_mismatches", 96'(bad), 96'(0));
        held = (h >= 0) ? 16'(h) : 16'(MAXRUN);
        core_halted = 1'b1;
        tick();
        core_halted = 1'b0;
        check("done_hold", done, 1);
        check("count_hold", cycle_count, held);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc;
        int nb;
        int h;
        logic [31:0] d;

        reset = 1'b1;
        start = 1'b0; load_valid = 1'b0; load_target = 1'b0; load_last = 1'b0;
        core_halted = 1'b0; load_address = '0; load_data = '0;
        b_start = 1'b0; b_load_valid = 1'b0; b_load_target = 1'b0; b_load_last = 1'b0;
        b_core_halted = 1'b0; b_load_address = '0; b_load_data = '0;
        tick();
        tick();

        check("rst_core_reset", core_reset, 1);
        check("rst_prog_we", prog_write_enable, 0);
        check("rst_data_we", data_write_enable, 0);
        check("rst_prog_addr", prog_write_address, 0);
        check("rst_prog_data", prog_write_data, 0);
        check("rst_data_addr", data_write_address, 0);
        check("rst_data_data", data_write_data, 0);
        check("rst_ready", load_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_count", cycle_count, 0);

        reset = 1'b0;
        tick();

        // Single program beat after idle cycles, then run to budget expiry.
        clear_and_check();
        repeat (3) tick();
        beats.delete();
        beats.push_back(mkbeat(1'b0, 6'h00, 32'h0000_100D));
        send_beats(1'b0, acc);
        run_phase(-1, acc);

        // Three beats with valid toggling; halt and budget coincide.
        clear_and_check();
        beats.delete();
        beats.push_back(mkbeat(1'b1, 6'h1C, 32'h5318_0008));
        beats.push_back(mkbeat(1'b1, 6'h30, 32'hDEAD_BEEF));
        beats.push_back(mkbeat(1'b0, 6'h00, $urandom));
        send_beats(1'b1, acc);
        run_phase(MAXRUN, acc);

        // 31-instruction program ending in HALT, halted after 35 cycles.
        clear_and_check();
        beats.delete();
        for (int i = 0; i < 30; i++) beats.push_back(mkbeat(1'b0, 6'(i), $urandom));
        beats.push_back(mkbeat(1'b0, 6'd30, {16'h0, HALT}));
        send_beats(1'b0, acc);
        run_phase(35, acc);

        // Randomized rounds over both memories.
        for (int r = 0; r < 4; r++) begin
            clear_and_check();
            beats.delete();
            nb = int'($urandom_range(1, 12));
            for (int i = 0; i < nb; i++)
                beats.push_back(mkbeat(1'($urandom_range(0, 1)), 6'($urandom), $urandom));
            h = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, MAXRUN));
            send_beats(1'($urandom_range(0, 1)), acc);
            run_phase(h, acc);
        end

        // Reset right after an accepted beat drops the pending strobe.
        clear_and_check();
        load_valid   = 1'b1;
        load_target  = 1'b0;
        load_address = 6'h05;
        load_data    = $urandom;
        load_last    = 1'b0;
        tick();
        load_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_prog_we", prog_write_enable, 0);
        check("midrst_data_we", data_write_enable, 0);
        check("midrst_ready", load_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_core_reset", core_reset, 1);
        check("midrst_done", done, 0);
        tick();
        check("midrst_no_strobe", 96'(log_q.size()), 96'(0));
        reset = 1'b0;
        tick();
        check("midrst_idle_busy", busy, 0);
        check("midrst_idle_core_reset", core_reset, 1);
        clear_and_check();
        beats.delete();
        beats.push_back(mkbeat(1'b1, 6'h2A, $urandom));
        beats.push_back(mkbeat(1'b0, 6'h3F, $urandom));
        send_beats(1'b0, acc);
        run_phase(3, acc);

        // Instance B: no clear phase, 4-bit data address truncation.
        b_log_q.delete();
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        check("b_ready_no_clear", b_load_ready, 1);
        check("b_busy", b_busy, 1);
        d = $urandom;
        b_load_valid   = 1'b1;
        b_load_target  = 1'b1;
        b_load_address = 6'h13;
        b_load_data    = d;
        b_load_last    = 1'b1;
        tick();
        acc = cyc;
        b_load_valid = 1'b0;
        b_load_last  = 1'b0;
        check("b_data_we", b_data_write_enable, 1);
        check("b_data_addr", b_data_write_address, 4'h3);
        check("b_data_data", b_data_write_data, d);
        check("b_prog_we", b_prog_write_enable, 0);
        check("b_core_reset_first", b_core_reset, 1);
        tick();
        check("b_core_reset_released", b_core_reset, 0);
        check("b_strobe_count", 96'(b_log_q.size()), 96'(1));
        if (b_log_q.size() > 0)
            check("b_strobe_entry", b_log_q[0], mk(1'b1, 6'h03, d, acc));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
